// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: FSM encodings, default timing, CTS# polarity and the
// transmit shifter payload. The receiver stage imports the same package.
package uart_tx_fifo_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;
  localparam int unsigned DEFAULT_DEPTH        = 16;
  localparam int unsigned DATA_W               = 8;
  localparam int unsigned STATE_W              = 2;
  localparam int unsigned BIT_IDX_W            = $clog2(DATA_W);

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_START = 2'd1;
  localparam logic [STATE_W-1:0] ST_DATA  = 2'd2;
  localparam logic [STATE_W-1:0] ST_STOP  = 2'd3;

  // CTS# is active-low: a low level means the host can accept data.
  localparam logic CTS_CLEAR = 1'b0;
  localparam logic LINE_IDLE = 1'b1;

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);

  typedef struct packed {
    logic [DATA_W-1:0]    shift;
    logic [BIT_IDX_W-1:0] bit_idx;
  } frame_t;

  // Serial line level for a given FSM state and current shifter LSB.
  function automatic logic line_level(input logic [STATE_W-1:0] st, input logic lsb);
    case (st)
      ST_START: line_level = 1'b0;
      ST_DATA:  line_level = lsb;
      default:  line_level = LINE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a show-ahead head.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  // Full/empty are registered, so a push on a full cycle drops even with a pop.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with input byte FIFO, gated by the active-low CTS# line.
// tx drives PMODL3, cts comes from PMODL2.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              ready,
  input  logic              cts,
  output logic              tx,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  head_c;
  logic               pop_c;
  logic               cts_meta;
  logic               cts_s;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [BAUD_W-1:0]  baud;
  logic [BAUD_W-1:0]  baud_next;
  logic               baud_done_c;
  frame_t             frame;
  frame_t             frame_next;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .reset   (reset),
    .push    (data_valid),
    .pop     (pop_c),
    .data_in (data_in),
    .head_c  (head_c),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ready       = ~fifo_full;
  assign baud_done_c = (baud == BAUD_LAST);

  // Two-stage CTS# synchroniser, parked at "not clear" during reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
    end else begin
      cts_meta <= cts;
      cts_s    <= cts_meta;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= ST_IDLE;
      baud  <= '0;
      frame <= '0;
    end else begin
      state <= state_next;
      baud  <= baud_next;
      frame <= frame_next;
    end
  end

  // CTS is only consulted in IDLE; a started frame always runs to its stop bit.
  always_comb begin
    state_next = state;
    baud_next  = baud;
    frame_next = frame;
    pop_c      = 1'b0;
    if (state != ST_IDLE) begin
      baud_next = baud_done_c ? '0 : baud + BAUD_W'(1);
    end
    case (state)
      ST_IDLE: begin
        baud_next = '0;
        if (!fifo_empty && (cts_s == CTS_CLEAR)) begin
          pop_c              = 1'b1;
          frame_next.shift   = head_c;
          frame_next.bit_idx = '0;
          state_next         = ST_START;
        end
      end
      ST_START: begin
        if (baud_done_c) begin
          frame_next.bit_idx = '0;
          state_next         = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_done_c) begin
          frame_next.shift = frame.shift >> 1;
          if (frame.bit_idx == LAST_BIT) begin
            state_next = ST_STOP;
          end else begin
            frame_next.bit_idx = frame.bit_idx + BIT_IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (baud_done_c) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      tx       <= LINE_IDLE;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx       <= line_level(state, frame.shift[0]);
      busy     <= (state != ST_IDLE) || !fifo_empty;
      overflow <= overflow | (data_valid & fifo_full);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line receiver decodes tx frames, and each scenario
// compares decoded bytes and start times against its own expected queue.
module tb_uart_tx_fifo;

  localparam int unsigned CPB     = 4;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned FRAME   = 10 * CPB;
  localparam int unsigned SPACING = FRAME + 1;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready;
  logic       cts;
  logic       tx;
  logic       busy;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic mon_abort = 1'b1;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ready      (ready),
    .cts        (cts),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Line receiver: one sample per cycle, frame must be exactly start/8 data/stop.
  initial begin : monitor
    logic [FRAME-1:0] s;
    logic [7:0]       b;
    logic             ok;
    logic             aborted;
    int               t0;
    forever begin
      @(negedge CLK);
      if (!mon_abort && tx === 1'b0) begin
        t0 = cyc;
        s = '0;
        aborted = 1'b0;
        for (int k = 1; k < int'(FRAME); k++) begin
          @(negedge CLK);
          if (mon_abort) begin
            aborted = 1'b1;
            break;
          end
          s[k] = tx;
        end
        if (!aborted) begin
          ok = 1'b1;
          b = '0;
          for (int k = 0; k < int'(CPB); k++) begin
            if (s[k] !== 1'b0) ok = 1'b0;
            if (s[int'(FRAME - CPB) + k] !== 1'b1) ok = 1'b0;
          end
          for (int i = 0; i < 8; i++) begin
            b[i] = s[int'(CPB) * (i + 1)];
            for (int k = 0; k < int'(CPB); k++)
              if (s[int'(CPB) * (i + 1) + k] !== b[i]) ok = 1'b0;
          end
          total++;
          if (!ok) begin
            bad++;
            $display("FAIL frame_shape t0=%0d: samples=%b required 4 low, 8x4 stable bits, 4 high", t0, s);
          end
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic write_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    @(negedge CLK);
    data_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int budget;
    budget = (n + 2) * int'(SPACING) + 50;
    while (rx_q.size() < n && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    if (rx_q.size() < n) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: frames=%0d required %0d", tag, rx_q.size(), n);
    end
  endtask

  task automatic wait_start(input string tag);
    int budget;
    budget = 20;
    while (tx !== 1'b0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    if (tx !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL %s_start_timeout: tx=%b required 0", tag, tx);
    end
  endtask

  task automatic clear_queues();
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; cts = 1'b0; data_valid = 1'b0; data_in = '0;
    tick(3);
    total += 4;
    if (tx !== 1'b1)       begin bad++; $display("FAIL reset_tx: got %b required 1", tx); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (ready !== 1'b1)    begin bad++; $display("FAIL reset_ready: got %b required 1", ready); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    reset = 1'b0;
    tick(3);
    mon_abort = 1'b0;
  endtask

  task automatic test_single();
    int c;
    clear_queues();
    exp_q.push_back(8'hA5);
    c = cyc;
    write_byte(8'hA5);
    tick(5);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_mid: got %b required 1", busy); end
    wait_frames(1, "single");
    tick(2);
    total += 4;
    if (rx_q.size() < 1 || rx_q[0] !== 8'hA5) begin
      bad++; $display("FAIL single_byte: got %h required a5", (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    if (rx_t.size() < 1 || rx_t[0] != c + 3) begin
      bad++; $display("FAIL single_latency: got %0d required %0d", (rx_t.size() > 0) ? rx_t[0] : -1, c + 3);
    end
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b required 0", busy); end
    if (tx !== 1'b1)   begin bad++; $display("FAIL single_tx_idle: got %b required 1", tx); end
  endtask

  task automatic test_fill_overflow();
    int model_cnt;
    int c;
    cts = 1'b1;
    tick(4);
    clear_queues();
    model_cnt = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      write_byte(8'(i));
      exp_q.push_back(8'(i));
      model_cnt++;
      total++;
      if (ready !== (model_cnt < int'(DEPTH))) begin
        bad++; $display("FAIL fill_ready%0d: got %b required %b", i, ready, model_cnt < int'(DEPTH));
      end
    end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_before: got %b required 0", overflow); end
    write_byte(8'hEE);
    total += 2;
    if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf_after: got %b required 1", overflow); end
    if (ready !== 1'b0)    begin bad++; $display("FAIL fill_ready_full: got %b required 0", ready); end
    tick(20);
    total += 2;
    if (rx_q.size() != 0) begin bad++; $display("FAIL fill_held: frames=%0d required 0", rx_q.size()); end
    if (tx !== 1'b1)      begin bad++; $display("FAIL fill_tx_idle: got %b required 1", tx); end
    c = cyc;
    cts = 1'b0;
    wait_frames(int'(DEPTH), "fill");
    tick(int'(SPACING) + 5);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("FAIL fill_count: frames=%0d required %0d", rx_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      total += 2;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL fill_byte%0d: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
      if (i >= rx_t.size() || rx_t[i] != c + 4 + i * int'(SPACING)) begin
        bad++; $display("FAIL fill_time%0d: got %0d required %0d", i, (i < rx_t.size()) ? rx_t[i] : -1, c + 4 + i * int'(SPACING));
      end
    end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf_sticky: got %b required 1", overflow); end
  endtask

  task automatic test_cts_midframe();
    logic [7:0] b0;
    logic [7:0] b1;
    int r;
    clear_queues();
    b0 = 8'($urandom); b1 = 8'($urandom);
    exp_q.push_back(b0); exp_q.push_back(b1);
    write_byte(b0);
    write_byte(b1);
    wait_start("cts");
    tick(17);
    cts = 1'b1;
    wait_frames(1, "cts_first");
    tick(60);
    total += 3;
    if (rx_q.size() != 1) begin bad++; $display("FAIL cts_hold: frames=%0d required 1", rx_q.size()); end
    if (busy !== 1'b1)    begin bad++; $display("FAIL cts_busy: got %b required 1", busy); end
    if (tx !== 1'b1)      begin bad++; $display("FAIL cts_tx_idle: got %b required 1", tx); end
    r = cyc;
    cts = 1'b0;
    wait_frames(2, "cts_second");
    total++;
    if (rx_t.size() < 2 || rx_t[1] != r + 4) begin
      bad++; $display("FAIL cts_resume_time: got %0d required %0d", (rx_t.size() > 1) ? rx_t[1] : -1, r + 4);
    end
    foreach (exp_q[i]) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL cts_byte%0d: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    tick(3);
  endtask

  task automatic test_push_pop();
    logic [7:0] b;
    cts = 1'b1;
    tick(4);
    clear_queues();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      write_byte(b);
    end
    total++;
    if (dut.u_fifo.count !== 5'd5) begin bad++; $display("FAIL pp_count_before: got %0d required 5", dut.u_fifo.count); end
    cts = 1'b0;
    tick(2);
    b = 8'($urandom);
    exp_q.push_back(b);
    write_byte(b);
    total += 2;
    if (dut.u_fifo.count !== 5'd5) begin bad++; $display("FAIL pp_count_after: got %0d required 5", dut.u_fifo.count); end
    if (ready !== 1'b1) begin bad++; $display("FAIL pp_ready: got %b required 1", ready); end
    wait_frames(6, "pp");
    foreach (exp_q[i]) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL pp_byte%0d: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    tick(3);
  endtask

  task automatic test_random();
    int n;
    int c;
    logic [7:0] b;
    clear_queues();
    n = $urandom_range(6, 12);
    c = cyc;
    for (int i = 0; i < n; i++) begin
      total++;
      if (ready !== 1'b1) begin bad++; $display("FAIL rnd_ready%0d: got %b required 1", i, ready); end
      b = 8'($urandom);
      exp_q.push_back(b);
      write_byte(b);
      tick($urandom_range(0, 3));
    end
    wait_frames(n, "rnd");
    total++;
    if (rx_t.size() < 1 || rx_t[0] != c + 3) begin
      bad++; $display("FAIL rnd_latency: got %0d required %0d", (rx_t.size() > 0) ? rx_t[0] : -1, c + 3);
    end
    foreach (exp_q[i]) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rnd_byte%0d: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
      if (i > 0) begin
        total++;
        if (i >= rx_t.size() || rx_t[i] - rx_t[i-1] != int'(SPACING)) begin
          bad++; $display("FAIL rnd_gap%0d: got %0d required %0d", i, (i < rx_t.size()) ? rx_t[i] - rx_t[i-1] : -1, SPACING);
        end
      end
    end
    tick(3);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int c;
    clear_queues();
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL rst_ovf_before: got %b required 1", overflow); end
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    wait_start("rst");
    tick(12);
    mon_abort = 1'b1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    total += 5;
    if (tx !== 1'b1)       begin bad++; $display("FAIL rst_tx: got %b required 1", tx); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (ready !== 1'b1)    begin bad++; $display("FAIL rst_ready: got %b required 1", ready); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b required 0", overflow); end
    if (dut.u_fifo.count !== 5'd0) begin bad++; $display("FAIL rst_fifo_empty: got %0d required 0", dut.u_fifo.count); end
    tick(1);
    total += 2;
    if (tx !== 1'b1)   begin bad++; $display("FAIL rst_tx_hold: got %b required 1", tx); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_hold: got %b required 0", busy); end
    tick(3);
    mon_abort = 1'b0;
    tick(3);
    clear_queues();
    b = 8'($urandom);
    exp_q.push_back(b);
    c = cyc;
    write_byte(b);
    wait_frames(1, "rst_fresh");
    total += 2;
    if (rx_q.size() < 1 || rx_q[0] !== b) begin
      bad++; $display("FAIL rst_fresh_byte: got %h required %h", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
    end
    if (rx_t.size() < 1 || rx_t[0] != c + 3) begin
      bad++; $display("FAIL rst_fresh_time: got %0d required %0d", (rx_t.size() > 0) ? rx_t[0] : -1, c + 3);
    end
    tick(3);
  endtask

  task automatic test_full_pop();
    logic [7:0] b;
    cts = 1'b1;
    tick(4);
    clear_queues();
    for (int i = 0; i < int'(DEPTH); i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      write_byte(b);
    end
    total += 2;
    if (ready !== 1'b0)    begin bad++; $display("FAIL fp_ready_full: got %b required 0", ready); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL fp_ovf_before: got %b required 0", overflow); end
    cts = 1'b0;
    tick(2);
    write_byte(8'h5A);
    total += 3;
    if (overflow !== 1'b1) begin bad++; $display("FAIL fp_ovf_after: got %b required 1", overflow); end
    if (ready !== 1'b1)    begin bad++; $display("FAIL fp_ready_after_pop: got %b required 1", ready); end
    if (dut.u_fifo.count !== 5'd15) begin bad++; $display("FAIL fp_count: got %0d required 15", dut.u_fifo.count); end
    wait_frames(int'(DEPTH), "fp");
    tick(int'(SPACING) + 5);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("FAIL fp_frame_count: frames=%0d required %0d", rx_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL fp_byte%0d: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_cts_midframe();
    test_push_pop();
    test_random();
    test_reset_midframe();
    test_full_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
